fixed_point_issue_queue: RTL

- Request buffer and sequencer directly upstream of the fixed-point unit (add/sub/mul/sqrt).
- Accepts tagged requests from the execute stage over a valid/ready handshake and queues them in a small FIFO.
- Issues one request at a time, holding operands and the operation code stable until the unit's ready is seen.
- Captures the result and returns it with its tag to writeback over a second valid/ready handshake.

---
 rtl/fixed_point_issue_queue.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fixed_point_issue_queue.sv
// fixed_point_issue_queue: FIFO-buffered request sequencer in front of the fixed-point unit
`ifndef FPU_ADD
`define FPU_ADD 2'd0
`endif
`ifndef FPU_SUB
`define FPU_SUB 2'd1
`endif
`ifndef FPU_MUL
`define FPU_MUL 2'd2
`endif
`ifndef FPU_SQRT
`define FPU_SQRT 2'd3
`endif

module fixed_point_issue_queue #(
   parameter int WIDTH   = 32,
   parameter int TAG_W   = 5,
   parameter int DEPTH   = 4,
   parameter int GAP     = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [TAG_W-1:0]         req_tag,
   input  logic [1:0]               req_operation,
   input  logic [WIDTH-1:0]         req_operand_1,
   input  logic [WIDTH-1:0]         req_operand_2,
   output logic [WIDTH-1:0]         fpu_operand_1,
   output logic [WIDTH-1:0]         fpu_operand_2,
   output logic [1:0]               fpu_operation,
   input  logic [WIDTH-1:0]         fpu_result,
   input  logic                     fpu_ready,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [TAG_W-1:0]         resp_tag,
   output logic [WIDTH-1:0]         resp_result,
   output logic                     resp_error,
   output logic [$clog2(DEPTH):0]   occupancy
);
   localparam int AW = $clog2(DEPTH);
   localparam int GW = $clog2(GAP + 2);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [1:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } entry_t;
   entry_t        mem [DEPTH];
   entry_t        iss;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [1:0]    state;
   logic [GW-1:0] gap_cnt;
   logic [TW-1:0] to_cnt;
   logic          push, pop, busy, short_op;
   assign req_ready     = count != (AW+1)'(DEPTH);
   assign push          = req_valid && req_ready;
   assign pop           = state == IDLE && count != '0 && gap_cnt == '0;
   assign occupancy     = count;
   assign resp_valid    = state == RESP;
   assign busy          = state == ISSUE || state == WAIT;
   assign short_op      = iss.op == `FPU_ADD || iss.op == `FPU_SUB;
   assign fpu_operation = busy ? iss.op : `FPU_ADD;
   assign fpu_operand_1 = busy ? iss.a : '0;
   assign fpu_operand_2 = busy ? iss.b : '0;
   // FIFO storage write; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{req_tag, req_operation, req_operand_1, req_operand_2};
   end
   // FIFO pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   // single-request sequencer: issue, wait for ready or timeout, hand back, then idle gap
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         gap_cnt     <= '0;
         to_cnt      <= '0;
         iss         <= '0;
         resp_tag    <= '0;
         resp_result <= '0;
         resp_error  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
               if (pop) begin
                  iss   <= mem[rd_ptr];
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               to_cnt   <= TW'(TIMEOUT - 1);
               resp_tag <= iss.tag;
               if (short_op && fpu_ready) begin
                  resp_result <= fpu_result;
                  resp_error  <= 1'b0;
                  state       <= RESP;
               end else state <= WAIT;
            end
            WAIT: begin
               if (fpu_ready) begin
                  resp_result <= fpu_result;
                  resp_error  <= 1'b0;
                  state       <= RESP;
               end else if (to_cnt == '0) begin
                  resp_result <= '0;
                  resp_error  <= 1'b1;
                  state       <= RESP;
               end else to_cnt <= to_cnt - 1'b1;
            end
            default: begin
               if (resp_ready) begin
                  gap_cnt <= GW'(GAP);
                  state   <= IDLE;
               end
            end
         endcase
      end
   end
endmodule
